// File: rtl/lsu_pipe_unit.sv
// Single-outstanding load/store unit between ALU and writeback, driving a req/gnt/rvalid bus.
// Optional bus watchdog: define LSU_BUS_TIMEOUT_EN (limit set by TIMEOUT_CYCLES).
`timescale 1ns/1ps
module lsu_pipe_unit #(
  parameter int unsigned DATA_W         = 32,
  parameter int unsigned ADDR_W         = 32,
  parameter int unsigned TIMEOUT_CYCLES = 64
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                req_valid_ip,
  output logic                req_ready_op,
  input  logic                req_we_ip,
  input  logic [1:0]          req_size_ip,
  input  logic                req_unsigned_ip,
  input  logic [ADDR_W-1:0]   req_addr_ip,
  input  logic [DATA_W-1:0]   req_wdata_ip,
  input  logic [4:0]          req_rd_ip,
  output logic                data_req_op,
  input  logic                data_gnt_ip,
  output logic [ADDR_W-1:0]   data_addr_op,
  output logic                data_we_op,
  output logic [DATA_W/8-1:0] data_be_op,
  output logic [DATA_W-1:0]   data_wdata_op,
  input  logic                data_rvalid_ip,
  input  logic [DATA_W-1:0]   data_rdata_ip,
  output logic                rsp_valid_op,
  output logic [DATA_W-1:0]   rsp_rdata_op,
  output logic [4:0]          rsp_rd_op,
  output logic                rsp_err_op,
  output logic                misalign_op,
  output logic                busy_op
);

  localparam int unsigned BeW  = DATA_W / 8;
  localparam int unsigned OffW = $clog2(BeW);

  if (!(DATA_W == 32 || DATA_W == 64) || TIMEOUT_CYCLES == 0) begin : g_param_check
    $error("lsu_pipe_unit: unsupported DATA_W or TIMEOUT_CYCLES");
  end

  typedef enum logic [1:0] {StIdle, StReq, StWait, StResp} state_e;

  state_e              state_q, state_d;
  logic                we_q;
  logic [1:0]          size_q;
  logic                uns_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [4:0]          rd_q;
  logic                err_q, err_d;
  logic                mis_q, mis_d;
  logic [DATA_W-1:0]   rdata_q, rdata_d;

  logic                accept;
  logic                req_illegal;
  logic                req_misalign;
  logic [OffW-1:0]     off;
  int unsigned         size_bits;
  logic [DATA_W-1:0]   rd_shift;
  logic [DATA_W-1:0]   load_ext;
  logic [DATA_W-1:0]   wdata_rep;
  logic [BeW-1:0]      be_base;

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int unsigned CntW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CntW-1:0] cnt_q, cnt_d;
`endif

  assign req_ready_op = (state_q == StIdle) || (state_q == StResp);
  assign accept       = req_valid_ip & req_ready_op;
  assign off          = addr_q[OffW-1:0];

  // An illegal size has no alignment rule, so it is reported as non-misaligned.
  always_comb begin
    req_illegal = (req_size_ip == 2'd3) && (DATA_W == 32);
    unique case (req_size_ip)
      2'd0:    req_misalign = 1'b0;
      2'd1:    req_misalign = req_addr_ip[0];
      2'd2:    req_misalign = |req_addr_ip[1:0];
      default: req_misalign = |req_addr_ip[2:0];
    endcase
  end

  always_comb begin
    size_bits = 32'd8 << size_q;
    rd_shift  = data_rdata_ip >> {off, 3'b000};
    load_ext  = '0;
    wdata_rep = '0;
    for (int unsigned i = 0; i < DATA_W; i++) begin
      if (i < size_bits) load_ext[i] = rd_shift[i];
      else               load_ext[i] = ~uns_q & rd_shift[size_bits-1];
      wdata_rep[i] = wdata_q[i & (size_bits - 1)];
    end
  end

  always_comb begin
    unique case (size_q)
      2'd0:    be_base = BeW'(8'h01);
      2'd1:    be_base = BeW'(8'h03);
      2'd2:    be_base = BeW'(8'h0F);
      default: be_base = BeW'(8'hFF);
    endcase
  end

  always_comb begin
    state_d = state_q;
    err_d   = err_q;
    mis_d   = mis_q;
    rdata_d = rdata_q;
    unique case (state_q)
      StIdle, StResp: begin
        state_d = StIdle;
        if (accept) begin
          rdata_d = '0;
          mis_d   = 1'b0;
          err_d   = 1'b0;
          if (req_illegal) begin
            state_d = StResp;
            err_d   = 1'b1;
          end else if (req_misalign) begin
            state_d = StResp;
            err_d   = 1'b1;
            mis_d   = 1'b1;
          end else begin
            state_d = StReq;
          end
        end
      end
      StReq: begin
        if (data_gnt_ip) state_d = StWait;
      end
      StWait: begin
        if (data_rvalid_ip) begin
          state_d = StResp;
          rdata_d = we_q ? '0 : load_ext;
        end
      end
      default: state_d = StIdle;
    endcase
`ifdef LSU_BUS_TIMEOUT_EN
    cnt_d = cnt_q;
    if (accept) begin
      cnt_d = '0;
    end else if (state_q == StReq || state_q == StWait) begin
      // A response arriving on the final cycle still wins over the watchdog.
      if (cnt_q == CntW'(TIMEOUT_CYCLES - 1) && !(state_q == StWait && data_rvalid_ip)) begin
        state_d = StResp;
        err_d   = 1'b1;
        mis_d   = 1'b0;
        rdata_d = '0;
      end else begin
        cnt_d = cnt_q + CntW'(1);
      end
    end
`endif
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= StIdle;
      we_q    <= 1'b0;
      size_q  <= 2'd0;
      uns_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rd_q    <= '0;
      err_q   <= 1'b0;
      mis_q   <= 1'b0;
      rdata_q <= '0;
`ifdef LSU_BUS_TIMEOUT_EN
      cnt_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      err_q   <= err_d;
      mis_q   <= mis_d;
      rdata_q <= rdata_d;
`ifdef LSU_BUS_TIMEOUT_EN
      cnt_q   <= cnt_d;
`endif
      if (accept) begin
        we_q    <= req_we_ip;
        size_q  <= req_size_ip;
        uns_q   <= req_unsigned_ip;
        addr_q  <= req_addr_ip;
        wdata_q <= req_wdata_ip;
        rd_q    <= req_rd_ip;
      end
    end
  end

  assign data_req_op   = (state_q == StReq);
  assign data_addr_op  = data_req_op ? {addr_q[ADDR_W-1:OffW], {OffW{1'b0}}} : '0;
  assign data_we_op    = data_req_op & we_q;
  assign data_be_op    = data_req_op ? (be_base << off) : '0;
  assign data_wdata_op = data_req_op ? wdata_rep : '0;

  assign rsp_valid_op  = (state_q == StResp);
  assign rsp_rdata_op  = rsp_valid_op ? rdata_q : '0;
  assign rsp_rd_op     = rsp_valid_op ? rd_q : '0;
  assign rsp_err_op    = rsp_valid_op & err_q;
  assign misalign_op   = rsp_valid_op & mis_q;
  assign busy_op       = (state_q == StReq) || (state_q == StWait);

endmodule

// File: tb/tb_lsu_pipe_unit.sv
// Scoreboard bench for lsu_pipe_unit: byte-level memory model, bus responder and response monitor.
`timescale 1ns/1ps
module tb_lsu_pipe_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        req_valid_ip, req_ready_op, req_we_ip, req_unsigned_ip;
  logic [1:0]  req_size_ip;
  logic [31:0] req_addr_ip, req_wdata_ip;
  logic [4:0]  req_rd_ip;
  logic        data_req_op, data_gnt_ip, data_we_op, data_rvalid_ip;
  logic [31:0] data_addr_op, data_wdata_op, data_rdata_ip;
  logic [3:0]  data_be_op;
  logic        rsp_valid_op, rsp_err_op, misalign_op, busy_op;
  logic [31:0] rsp_rdata_op;
  logic [4:0]  rsp_rd_op;

  lsu_pipe_unit #(.DATA_W(32), .ADDR_W(32), .TIMEOUT_CYCLES(64)) dut (
    .clock(clock), .reset(reset),
    .req_valid_ip(req_valid_ip), .req_ready_op(req_ready_op), .req_we_ip(req_we_ip),
    .req_size_ip(req_size_ip), .req_unsigned_ip(req_unsigned_ip), .req_addr_ip(req_addr_ip),
    .req_wdata_ip(req_wdata_ip), .req_rd_ip(req_rd_ip),
    .data_req_op(data_req_op), .data_gnt_ip(data_gnt_ip), .data_addr_op(data_addr_op),
    .data_we_op(data_we_op), .data_be_op(data_be_op), .data_wdata_op(data_wdata_op),
    .data_rvalid_ip(data_rvalid_ip), .data_rdata_ip(data_rdata_ip),
    .rsp_valid_op(rsp_valid_op), .rsp_rdata_op(rsp_rdata_op), .rsp_rd_op(rsp_rd_op),
    .rsp_err_op(rsp_err_op), .misalign_op(misalign_op), .busy_op(busy_op)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic [31:0] rdata; logic [4:0] rd; logic err; logic mis; int lat; int acc;
  } rsp_t;
  typedef struct { logic [31:0] addr; logic we; logic [3:0] be; logic [31:0] wdata; } breq_t;
  typedef struct { int gd; int rvd; } tim_t;

  rsp_t        rsp_q[$];
  breq_t       breq_q[$];
  tim_t        tim_q[$];
  logic [7:0]  ref_mem [int unsigned];
  logic [31:0] bus_mem [int unsigned];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          mem_en = 1'b1;
  bit          force_rv = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] init_byte(input int unsigned a);
    return 8'((a * 32'd37) ^ (a >> 5) ^ 32'h5A);
  endfunction

  function automatic logic [7:0] ref_rd(input int unsigned a);
    return ref_mem.exists(a) ? ref_mem[a] : init_byte(a);
  endfunction

  function automatic logic [31:0] bus_rd(input int unsigned w);
    return bus_mem.exists(w) ? bus_mem[w]
         : {init_byte(w + 3), init_byte(w + 2), init_byte(w + 1), init_byte(w)};
  endfunction

  // Bus responder: grants after gd cycles, responds rvd cycles after the grant.
  int    phase = 0, gl = 0, rl = 0;
  bit    cur_chk = 1'b0;
  breq_t cur;
  initial begin
    tim_t        t;
    logic [31:0] w;
    data_gnt_ip = 1'b0; data_rvalid_ip = 1'b0; data_rdata_ip = '0;
    forever begin
      @(negedge clock);
      data_gnt_ip = 1'b0; data_rvalid_ip = 1'b0; data_rdata_ip = $urandom;
      if (!mem_en) begin
        data_rvalid_ip = force_rv;
        phase = 0;
      end else begin
        if (phase == 0 && data_req_op === 1'b1) begin
          if (breq_q.size() == 0 || tim_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_data_req actual=1 required=0 (t=%0t)", $time);
            cur_chk = 1'b0; gl = 0; rl = 0;
          end else begin
            cur = breq_q.pop_front(); t = tim_q.pop_front(); cur_chk = 1'b1;
            gl = (t.gd < 0) ? int'($urandom_range(0, 4)) : t.gd;
            rl = (t.rvd < 0) ? int'($urandom_range(0, 3)) : t.rvd;
          end
          phase = 1;
        end
        if (phase == 1) begin
          if (cur_chk)
            check("req_hold", 64'({data_req_op, data_addr_op, data_we_op, data_be_op, data_wdata_op}),
                  64'({1'b1, cur.addr, cur.we, cur.be, cur.wdata}));
          if ($urandom_range(0, 3) == 0) data_rvalid_ip = 1'b1;  // must be ignored in REQ
          if (gl == 0) begin
            data_gnt_ip = 1'b1;
            phase = 2;
            if (cur_chk && cur.we) begin
              w = bus_rd(cur.addr);
              for (int k = 0; k < 4; k++) if (cur.be[k]) w[8*k +: 8] = cur.wdata[8*k +: 8];
              bus_mem[cur.addr] = w;
            end
          end else gl--;
        end else if (phase == 2) begin
          check("req_low_in_wait", 64'(data_req_op), 64'd0);
          if (rl == 0) begin
            data_rvalid_ip = 1'b1;
            data_rdata_ip  = bus_rd(cur.addr);
            phase = 0;
          end else rl--;
        end
      end
    end
  end

  // Response monitor
  initial begin
    rsp_t e;
    forever begin
      @(negedge clock);
      if (rsp_valid_op === 1'b1) begin
        if (rsp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_rsp actual rsp_valid=1 rd=%0d required no response (t=%0t)",
                   rsp_rd_op, $time);
        end else begin
          e = rsp_q.pop_front();
          check("rsp", 64'({rsp_rdata_op, rsp_rd_op, rsp_err_op, misalign_op}),
                64'({e.rdata, e.rd, e.err, e.mis}));
          if (e.lat >= 0) check("latency", 64'(cyc - e.acc), 64'(e.lat));
        end
      end
    end
  end

  // Issue one op; the reference model computes the response and the expected bus request.
  task automatic issue(input bit we, input logic [1:0] size, input bit uns,
                       input logic [31:0] addr, input logic [31:0] wdata, input logic [4:0] rd,
                       input int gd, input int rvd, input bit use_exp, input logic [31:0] exp_rdata);
    rsp_t            e;
    breq_t           b;
    tim_t            t;
    int              n;
    int unsigned     nb;
    longint unsigned v;
    @(negedge clock);
    req_valid_ip = 1'b0; req_we_ip = 1'($urandom); req_size_ip = 2'($urandom);
    req_addr_ip = $urandom; req_wdata_ip = $urandom; req_rd_ip = 5'($urandom);
    n = 0;
    while (req_ready_op !== 1'b1 && n < 100) begin @(negedge clock); n++; end
    if (req_ready_op !== 1'b1) begin
      checks++; errors++;
      $display("FAIL ready_timeout actual ready=%b required=1", req_ready_op);
      return;
    end
    req_valid_ip = 1'b1; req_we_ip = we; req_size_ip = size; req_unsigned_ip = uns;
    req_addr_ip = addr; req_wdata_ip = wdata; req_rd_ip = rd;
    nb = 32'd1 << size;
    e.rd = rd; e.acc = cyc; e.rdata = '0; e.err = 1'b0; e.mis = 1'b0;
    if (size == 2'd3) begin
      e.err = 1'b1; e.lat = 1;
    end else if (addr % nb != 0) begin
      e.err = 1'b1; e.mis = 1'b1; e.lat = 1;
    end else begin
      e.lat = (gd >= 0 && rvd >= 0) ? 3 + gd + rvd : -1;
      b.addr = addr & ~32'h3; b.we = we;
      b.be = 4'(((32'd1 << nb) - 1) << (addr % 4));
      for (int k = 0; k < 4; k++) b.wdata[8*k +: 8] = wdata[8*(k % int'(nb)) +: 8];
      if (we) begin
        for (int i = 0; i < int'(nb); i++) ref_mem[addr + i] = wdata[8*i +: 8];
      end else begin
        v = 0;
        for (int i = 0; i < int'(nb); i++) v |= longint'(ref_rd(addr + i)) << (8 * i);
        if (!uns && v[8*nb-1]) v |= ~((64'd1 << (8 * nb)) - 1);
        e.rdata = v[31:0];
      end
      t.gd = gd; t.rvd = rvd;
      breq_q.push_back(b); tim_q.push_back(t);
    end
    if (use_exp) e.rdata = exp_rdata;
    rsp_q.push_back(e);
  endtask

  task automatic drain(input string name);
    int n = 0;
    @(negedge clock); req_valid_ip = 1'b0;
    while (rsp_q.size() != 0 && n < 300) begin @(negedge clock); n++; end
    check(name, 64'(rsp_q.size()), 64'd0);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog actual=hung required=finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int          sr, cnt, n;
    logic [1:0]  sz;
    logic [31:0] a;
    reset = 1'b0; req_valid_ip = 1'b0; req_we_ip = 1'b0; req_size_ip = '0;
    req_unsigned_ip = 1'b0; req_addr_ip = '0; req_wdata_ip = '0; req_rd_ip = '0;
    repeat (2) @(negedge clock);
    check("reset_outputs", 64'({req_ready_op, data_req_op, data_addr_op, data_we_op, data_be_op,
          data_wdata_op, rsp_valid_op, rsp_rdata_op, rsp_rd_op, rsp_err_op, misalign_op, busy_op}),
          64'({1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0}));
    reset = 1'b1;

    bus_mem[32'h1000] = 32'h80FF_FF7F;
    ref_mem[32'h1000] = 8'h7F; ref_mem[32'h1001] = 8'hFF;
    ref_mem[32'h1002] = 8'hFF; ref_mem[32'h1003] = 8'h80;

    issue(1'b0, 2'd0, 1'b0, 32'h1003, 32'h0, 5'd1, 0, 0, 1'b1, 32'hFFFF_FF80);  // LB
    issue(1'b0, 2'd0, 1'b1, 32'h1003, 32'h0, 5'd2, 0, 0, 1'b1, 32'h0000_0080);  // LBU
    issue(1'b1, 2'd1, 1'b0, 32'h2002, 32'h0000_BEEF, 5'd3, 0, 1, 1'b1, 32'h0);  // SH
    issue(1'b0, 2'd2, 1'b0, 32'h3001, 32'h0, 5'd7, 0, 0, 1'b1, 32'h0);          // misaligned LW
    issue(1'b0, 2'd3, 1'b0, 32'h3000, 32'h0, 5'd8, 0, 0, 1'b1, 32'h0);          // illegal size
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 5'd4, 3, 0, 1'b1, 32'h80FF_FF7F);  // gnt held off
    issue(1'b0, 2'd2, 1'b0, 32'h2000, 32'h0, 5'd5, 0, 0, 1'b1, 32'hBEEF_0000 |
          {init_byte(32'h2001), init_byte(32'h2000)});
    issue(1'b0, 2'd1, 1'b1, 32'h2002, 32'h0, 5'd6, 0, 0, 1'b1, 32'h0000_BEEF);  // back-to-back
    drain("drain_directed");

    for (int i = 0; i < 250; i++) begin
      sr = int'($urandom_range(0, 9));
      sz = (sr < 3) ? 2'd0 : (sr < 6) ? 2'd1 : (sr < 9) ? 2'd2 : 2'd3;
      a  = {26'd0, 6'($urandom)};
      if (sz == 2'd3) a = a & ~32'h7;
      else if ($urandom_range(0, 4) != 0) a = a & ~((32'd1 << sz) - 1);
      if ($urandom_range(0, 3) == 0) begin
        n = int'($urandom_range(1, 3));
        repeat (n) begin @(negedge clock); req_valid_ip = 1'b0; end
      end
      if ($urandom_range(0, 4) == 0)
        issue(1'($urandom), sz, 1'($urandom), a, $urandom, 5'($urandom), 0, 0, 1'b0, 32'h0);
      else
        issue(1'($urandom), sz, 1'($urandom), a, $urandom, 5'($urandom), -1, -1, 1'b0, 32'h0);
    end
    drain("drain_random");

    // Reset while waiting for rvalid; a late rvalid must not produce a response.
    issue(1'b0, 2'd2, 1'b0, 32'h1000, 32'h0, 5'd9, 0, 6, 1'b0, 32'h0);
    n = 0;
    do begin @(negedge clock); req_valid_ip = 1'b0; n++; end
    while (!(busy_op === 1'b1 && data_req_op === 1'b0) && n < 20);
    check("reached_wait", 64'({busy_op, data_req_op}), 64'(2'b10));
    mem_en = 1'b0;
    reset = 1'b0;
    #1;
    check("reset_in_wait", 64'({req_ready_op, data_req_op, data_addr_op, data_we_op, data_be_op,
          data_wdata_op, rsp_valid_op, rsp_rdata_op, rsp_rd_op, rsp_err_op, misalign_op, busy_op}),
          64'({1'b1, 1'b0, 32'd0, 1'b0, 4'd0, 32'd0, 1'b0, 32'd0, 5'd0, 1'b0, 1'b0, 1'b0}));
    rsp_q.delete(); breq_q.delete(); tim_q.delete();
    repeat (2) @(negedge clock);
    reset = 1'b1;
    @(negedge clock); force_rv = 1'b1;
    @(negedge clock); force_rv = 1'b0;
    cnt = 0;
    repeat (6) begin @(negedge clock); if (rsp_valid_op === 1'b1) cnt++; end
    check("no_rsp_after_reset", 64'(cnt), 64'd0);
    check("idle_after_late_rvalid", 64'({busy_op, req_ready_op}), 64'(2'b01));
    mem_en = 1'b1;

    issue(1'b1, 2'd2, 1'b0, 32'h40, 32'h1234_5678, 5'd10, 0, 0, 1'b0, 32'h0);
    issue(1'b0, 2'd1, 1'b0, 32'h42, 32'h0, 5'd11, 0, 0, 1'b1, 32'h0000_1234);
    drain("drain_recovery");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
